// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and forwarding control for a 5-stage in-order pipeline.
//
// A three-slot tracker (EX, MEM, WB) records in-flight register writers. Every cycle
// the ID-stage sources are compared against it to pick forwarding sources and to
// decide whether ID must stall or be flushed.
//
// Optional feature, selected by the macro HAZARD_FORWARDING_EN:
//   defined   - operand forwarding; only a load in EX that is needed by ID stalls
//   undefined - no forwarding; any source matching any tracker slot stalls ID
//
// Ports:
//   clk               pipeline clock
//   rst               asynchronous active-low reset
//   id_valid          ID holds a real instruction
//   id_rs1, id_rs2    ID source registers
//   id_rd             ID destination register (0 = no write)
//   id_ready_at       stage producing ID's result: 2 = MEM (load), any other value = EX
//   mem_busy          memory stage cannot complete this cycle
//   ex_branch_taken   redirect resolved in EX
//   stall             hold PC, IF/ID and ID
//   flush_if_id       squash IF/ID
//   bubble_id_ex      load a NOP into ID/EX
//   fwd_sel_rs1/rs2   operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
//   state             FSM state (RUN=0, HAZ=1, MEMW=2, FLUSH=3), one cycle behind
//   stall_cnt         saturating count of stalled cycles
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_ready_at,
    input  logic        mem_busy,
    input  logic        ex_branch_taken,
    output logic        stall,
    output logic        flush_if_id,
    output logic        bubble_id_ex,
    output logic [1:0]  fwd_sel_rs1,
    output logic [1:0]  fwd_sel_rs2,
    output logic [1:0]  state,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StHaz   = 2'd1,
        StMemw  = 2'd2,
        StFlush = 2'd3
    } state_e;

    localparam logic [1:0] RdyEx  = 2'd1;
    localparam logic [1:0] RdyMem = 2'd2;

    state_e      state_q, state_d;
    logic [15:0] stall_cnt_q;

    // Writer tracker
    logic        ex_v_q, mem_v_q, wb_v_q;
    logic [4:0]  ex_rd_q, mem_rd_q, wb_rd_q;
    logic [1:0]  ex_rdy_q, mem_rdy_q;

    logic        m_ex1, m_ex2, m_mem1, m_mem2, m_wb1, m_wb2;
    logic        hazard;
    logic        advance;
    logic        ex_new_v;
    logic [1:0]  ex_new_rdy;
    logic        stall_raw, flush_raw, bubble_raw;

    function automatic logic src_match(input logic v, input logic [4:0] rd,
                                       input logic [4:0] rs);
        return v && (rs != 5'd0) && (rs == rd);
    endfunction

    always_comb begin
        m_ex1  = src_match(ex_v_q,  ex_rd_q,  id_rs1);
        m_ex2  = src_match(ex_v_q,  ex_rd_q,  id_rs2);
        m_mem1 = src_match(mem_v_q, mem_rd_q, id_rs1);
        m_mem2 = src_match(mem_v_q, mem_rd_q, id_rs2);
        m_wb1  = src_match(wb_v_q,  wb_rd_q,  id_rs1);
        m_wb2  = src_match(wb_v_q,  wb_rd_q,  id_rs2);
    end

`ifdef HAZARD_FORWARDING_EN
    // Only a load still in EX is too late to forward; everything else is bypassed.
    assign hazard = id_valid && (m_ex1 || m_ex2) && (ex_rdy_q == RdyMem);

    always_comb begin
        fwd_sel_rs1 = 2'd0;
        if (m_ex1)       fwd_sel_rs1 = 2'd1;
        else if (m_mem1) fwd_sel_rs1 = 2'd2;
        else if (m_wb1)  fwd_sel_rs1 = 2'd3;
        fwd_sel_rs2 = 2'd0;
        if (m_ex2)       fwd_sel_rs2 = 2'd1;
        else if (m_mem2) fwd_sel_rs2 = 2'd2;
        else if (m_wb2)  fwd_sel_rs2 = 2'd3;
    end

    // MEM-stage ready_at is tracked but no decision depends on it yet.
    logic unused_rdy;
    assign unused_rdy = ^mem_rdy_q;
`else
    // Without bypassing, ID waits until the writer has left WB.
    assign hazard = id_valid && (m_ex1 || m_ex2 || m_mem1 || m_mem2 || m_wb1 || m_wb2);

    assign fwd_sel_rs1 = 2'd0;
    assign fwd_sel_rs2 = 2'd0;

    logic unused_rdy;
    assign unused_rdy = ^{ex_rdy_q, mem_rdy_q};
`endif

    // 0 and 3 both mean "result at end of EX".
    assign ex_new_rdy = (id_ready_at == RdyMem) ? RdyMem : RdyEx;

    always_comb begin
        state_d    = StRun;
        advance    = 1'b1;
        ex_new_v   = id_valid && (id_rd != 5'd0);
        stall_raw  = 1'b0;
        flush_raw  = 1'b0;
        bubble_raw = 1'b0;
        if (mem_busy) begin
            // Freeze everything; a concurrent branch must be held by its source.
            state_d   = StMemw;
            advance   = 1'b0;
            stall_raw = 1'b1;
        end else if (ex_branch_taken) begin
            state_d    = StFlush;
            ex_new_v   = 1'b0;
            flush_raw  = 1'b1;
            bubble_raw = 1'b1;
        end else if (hazard) begin
            state_d    = StHaz;
            ex_new_v   = 1'b0;
            stall_raw  = 1'b1;
            bubble_raw = 1'b1;
        end
    end

    // Keep controls quiet while reset is held, whatever the inputs do.
    assign stall        = rst & stall_raw;
    assign flush_if_id  = rst & flush_raw;
    assign bubble_id_ex = rst & bubble_raw;
    assign state        = state_q;
    assign stall_cnt    = stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StRun;
            stall_cnt_q <= 16'd0;
            ex_v_q      <= 1'b0;
            ex_rd_q     <= 5'd0;
            ex_rdy_q    <= RdyEx;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= 5'd0;
            mem_rdy_q   <= RdyEx;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= 5'd0;
        end else begin
            state_q <= state_d;
            if (stall_raw && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (advance) begin
                wb_v_q    <= mem_v_q;
                wb_rd_q   <= mem_rd_q;
                mem_v_q   <= ex_v_q;
                mem_rd_q  <= ex_rd_q;
                mem_rdy_q <= ex_rdy_q;
                ex_v_q    <= ex_new_v;
                ex_rd_q   <= id_rd;
                ex_rdy_q  <= ex_new_rdy;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl. The stimulus process drives one ID/control
// vector per cycle and queues the hand-derived expected outputs; the monitor pops and
// compares on each falling edge. Vectors follow the build's HAZARD_FORWARDING_EN setting.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [1:0]  id_ready_at;
    logic        mem_busy, ex_branch_taken;
    logic        stall, flush_if_id, bubble_id_ex;
    logic [1:0]  fwd_sel_rs1, fwd_sel_rs2, state;
    logic [15:0] stall_cnt;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       nm;
        logic        st;
        logic        fl;
        logic        bb;
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [1:0]  sm;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] cnt_model = 16'd0;

    pipe_hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rd           (id_rd),
        .id_ready_at     (id_ready_at),
        .mem_busy        (mem_busy),
        .ex_branch_taken (ex_branch_taken),
        .stall           (stall),
        .flush_if_id     (flush_if_id),
        .bubble_id_ex    (bubble_id_ex),
        .fwd_sel_rs1     (fwd_sel_rs1),
        .fwd_sel_rs2     (fwd_sel_rs2),
        .state           (state),
        .stall_cnt       (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cmp(input string nm, input string fld, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: the DUT presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.nm, "stall",  {15'd0, stall},        {15'd0, e.st});
                cmp(e.nm, "flush",  {15'd0, flush_if_id},  {15'd0, e.fl});
                cmp(e.nm, "bubble", {15'd0, bubble_id_ex}, {15'd0, e.bb});
                cmp(e.nm, "fwd1",   {14'd0, fwd_sel_rs1},  {14'd0, e.f1});
                cmp(e.nm, "fwd2",   {14'd0, fwd_sel_rs2},  {14'd0, e.f2});
                cmp(e.nm, "state",  {14'd0, state},        {14'd0, e.sm});
                cmp(e.nm, "cnt",    stall_cnt,             e.cnt);
            end
        end
    end

    task automatic push(input string nm, input logic es, input logic ef, input logic eb,
                        input logic [1:0] e1, input logic [1:0] e2, input logic [1:0] esm);
        exp_t e;
        e.nm  = nm;
        e.st  = es;
        e.fl  = ef;
        e.bb  = eb;
        e.f1  = e1;
        e.f2  = e2;
        e.sm  = esm;
        e.cnt = cnt_model;
        exp_q.push_back(e);
    endtask

    // One pipeline cycle: drive inputs after the edge, queue expected outputs.
    task automatic step(input string nm, input logic v, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] rd, input logic [1:0] rdy,
                        input logic busy, input logic br, input logic es, input logic ef,
                        input logic eb, input logic [1:0] e1, input logic [1:0] e2,
                        input logic [1:0] esm, input bit chk);
        @(posedge clk);
        #1;
        id_valid        = v;
        id_rs1          = r1;
        id_rs2          = r2;
        id_rd           = rd;
        id_ready_at     = rdy;
        mem_busy        = busy;
        ex_branch_taken = br;
        if (chk) push(nm, es, ef, eb, e1, e2, esm);
        if (es && (cnt_model != 16'hFFFF)) cnt_model++;
    endtask

    initial begin
        // Reset with busy/branch asserted: controls must stay low.
        rst             = 1'b0;
        id_valid        = 1'b1;
        id_rs1          = 5'd1;
        id_rs2          = 5'd2;
        id_rd           = 5'd3;
        id_ready_at     = 2'd2;
        mem_busy        = 1'b1;
        ex_branch_taken = 1'b1;
        #1;
        push("reset", 0, 0, 0, 0, 0, 0);
        #11;
        mem_busy        = 1'b0;
        ex_branch_taken = 1'b0;
        id_valid        = 1'b0;
        rst             = 1'b1;

`ifdef HAZARD_FORWARDING_EN
        //    name      v  rs1 rs2 rd  rdy bsy br  st fl bb f1 f2 sm
        step("alu_x5",   1, 1,  2,  5,  1,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("fwd_ex",   1, 5,  0,  6,  1,  0,  0,  0, 0, 0, 1, 0, 0, 1);
        step("fwd_mem",  1, 5,  6,  0,  1,  0,  0,  0, 0, 0, 2, 1, 0, 1);
        step("fwd_wb",   1, 5,  6,  0,  1,  0,  0,  0, 0, 0, 3, 2, 0, 1);
        step("fwd_wb2",  1, 5,  6,  0,  1,  0,  0,  0, 0, 0, 0, 3, 0, 1);
        step("ld_x7",    1, 1,  2,  7,  2,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("lu_stall", 1, 7,  0,  8,  1,  0,  0,  1, 0, 1, 1, 0, 0, 1);
        step("lu_go",    1, 7,  0,  8,  1,  0,  0,  0, 0, 0, 2, 0, 1, 1);
        step("fwd_mix",  1, 8,  7,  0,  1,  0,  0,  0, 0, 0, 1, 3, 0, 1);
        step("ld_x9",    1, 0,  0,  9,  2,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("busy1",    1, 9,  9, 10,  1,  1,  0,  1, 0, 0, 1, 1, 0, 1);
        step("busy2",    1, 9,  9, 10,  1,  1,  0,  1, 0, 0, 1, 1, 2, 1);
        step("busy3",    1, 9,  9, 10,  1,  1,  0,  1, 0, 0, 1, 1, 2, 1);
        step("busy4",    1, 9,  9, 10,  1,  1,  0,  1, 0, 0, 1, 1, 2, 1);
        step("busy_lu",  1, 9,  9, 10,  1,  0,  0,  1, 0, 1, 1, 1, 2, 1);
        step("busy_go",  1, 9,  9, 10,  1,  0,  0,  0, 0, 0, 2, 2, 1, 1);
        step("ld_x11",   1, 0,  0, 11,  2,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("br_lu",    1, 11, 10, 12, 1,  0,  1,  0, 1, 1, 1, 2, 0, 1);
        step("post_br",  1, 0,  0,  0,  1,  0,  0,  0, 0, 0, 0, 0, 3, 1);
        step("busy_br",  1, 0,  0,  0,  1,  1,  1,  1, 0, 0, 0, 0, 0, 1);
        step("post_bb",  1, 0,  0,  0,  1,  0,  0,  0, 0, 0, 0, 0, 2, 1);
        step("ld_x13",   1, 0,  0, 13,  2,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("haz_x13",  1, 13, 0,  0,  1,  0,  0,  1, 0, 1, 1, 0, 0, 1);
`else
        //    name      v  rs1 rs2 rd  rdy bsy br  st fl bb f1 f2 sm
        step("alu_x3",   1, 1,  2,  3,  1,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("raw_ex",   1, 3,  0,  4,  1,  0,  0,  1, 0, 1, 0, 0, 0, 1);
        step("raw_mem",  1, 3,  0,  4,  1,  0,  0,  1, 0, 1, 0, 0, 1, 1);
        step("raw_wb",   1, 3,  0,  4,  1,  0,  0,  1, 0, 1, 0, 0, 1, 1);
        step("raw_go",   1, 3,  0,  4,  1,  0,  0,  0, 0, 0, 0, 0, 1, 1);
        step("invalid",  0, 4,  4,  0,  1,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("br_haz",   1, 4,  0,  5,  1,  0,  1,  0, 1, 1, 0, 0, 0, 1);
        step("post_br",  1, 0,  0,  0,  1,  0,  0,  0, 0, 0, 0, 0, 3, 1);
        step("busy_br",  1, 0,  0,  0,  1,  1,  1,  1, 0, 0, 0, 0, 0, 1);
        step("post_bb",  1, 0,  0,  0,  1,  0,  0,  0, 0, 0, 0, 0, 2, 1);
        step("ld_x13",   1, 0,  0, 13,  2,  0,  0,  0, 0, 0, 0, 0, 0, 1);
        step("haz_x13",  1, 13, 0,  0,  1,  0,  0,  1, 0, 1, 0, 0, 0, 1);
`endif

        // Reset mid-HAZ with busy/branch asserted: everything clears at once.
        @(posedge clk);
        #2;
        mem_busy        = 1'b1;
        ex_branch_taken = 1'b1;
        rst             = 1'b0;
        cnt_model       = 16'd0;
        push("rst_haz", 0, 0, 0, 0, 0, 0);
        #10;
        mem_busy        = 1'b0;
        ex_branch_taken = 1'b0;
        rst             = 1'b1;
        // Same ID instruction, but the tracker is empty after reset.
        step("rst_post", 1, 13, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Saturation: hold mem_busy for 70000 cycles.
        for (int i = 0; i < 70000; i++) begin
            step("sat_fill", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 2, 0);
        end
        step("sat_busy", 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 2, 1);
        step("sat_hold", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2, 1);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  pipeline clock; rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-002 SHALL have ports: id_valid  in  1  ID holds a real instruction; id_rs1, id_rs2  in  5 each  ID source registers; id_rd  in  5  ID destination (0 = no write).
REQ-003 SHALL have port: id_ready_at  in  2  stage whose end produces ID's result: 1=EX (ALU), 2=MEM (load); 0/3 treated as 1.
REQ-004 SHALL have ports: mem_busy  in  1  memory stage cannot complete this cycle; ex_branch_taken  in  1  redirect resolved in EX.
REQ-005 SHALL have ports: stall  out  1  hold PC, IF/ID and ID; flush_if_id  out  1  squash IF/ID; bubble_id_ex  out  1  load NOP into ID/EX.
REQ-006 SHALL have ports: fwd_sel_rs1, fwd_sel_rs2  out  2 each  operand source for ID: 0 regfile, 1 EX result, 2 MEM result, 3 WB result.
REQ-007 SHALL have ports: state  out  2  FSM state; stall_cnt  out  16  saturating count of stalled cycles.

Function
REQ-008 SHALL keep a tracker of in-flight writers: EX slot {v, rd, ready_at}, MEM slot {v, rd, ready_at}, WB slot {v, rd}.
REQ-009 A source SHALL match a slot only if slot v=1, rs != 0 and rs == slot rd; youngest match (EX > MEM > WB) wins.
REQ-010 Load-use hazard SHALL be: id_valid=1 and an ID source matches the EX slot with ready_at=2.
REQ-011 fwd_sel SHALL be combinational: 1/2/3 for youngest matching EX/MEM/WB slot, else 0.
REQ-012 FSM states SHALL be RUN=0, HAZ=1, MEMW=2, FLUSH=3; priority each cycle: mem_busy > ex_branch_taken > load-use > none.
REQ-013 mem_busy=1: next state MEMW; stall=1, flush_if_id=0, bubble_id_ex=0; tracker holds all slots unchanged.
REQ-014 ex_branch_taken=1 (mem_busy=0): next state FLUSH; flush_if_id=1, bubble_id_ex=1, stall=0; tracker advances with EX slot loaded v=0.
REQ-015 Load-use (no higher event): next state HAZ; stall=1, bubble_id_ex=1; tracker advances with EX slot v=0; exactly one stall cycle per load-use pair with forwarding.
REQ-016 No event: next state RUN; outputs 0; tracker advances, EX slot <= {id_valid && id_rd!=0, id_rd, id_ready_at}.
REQ-017 Advance SHALL mean WB <= MEM, MEM <= EX, EX <= new entry, in one clk edge.
REQ-018 All control outputs SHALL be combinational from current inputs and tracker; state reflects last decision (one-cycle latency).
REQ-019 stall_cnt SHALL increment on each clk edge where stall=1 and saturate at 16'hFFFF.
REQ-020 Simultaneous mem_busy and ex_branch_taken: branch SHALL be ignored that cycle; source must hold it until mem_busy=0.

Reset
REQ-021 rst=0 SHALL immediately clear all tracker v bits, state=RUN, stall_cnt=0; with no valid slots, stall, flush_if_id and bubble_id_ex SHALL be 0 during reset.
REQ-022 Reset asserted mid-stall or mid-flush SHALL abort it; first cycle after release behaves as RUN with empty tracker.

Configuration
REQ-023 Macro HAZARD_FORWARDING_EN defined: behaviour per REQ-010/011/015.
REQ-024 HAZARD_FORWARDING_EN undefined: fwd_sel_rs1/rs2 SHALL be 0; hazard SHALL be any ID source matching EX, MEM or WB slot regardless of ready_at; handled as REQ-015 (HAZ, stall+bubble) until no match.

Verification
REQ-025 Forwarding on: ALU writes x5, next instr reads x5 -> fwd_sel_rs1=1, stall=0; one cycle later (x5 now in MEM) -> fwd_sel=2.
REQ-026 Forwarding on: load to x7 (id_ready_at=2), next reads x7 -> one cycle stall=1, bubble_id_ex=1, state=HAZ; next cycle fwd_sel=2, stall=0; stall_cnt=1.
REQ-027 Forwarding off: ALU writes x3, next reads x3 -> stall=1 for exactly 3 cycles, then fwd_sel=0, stall=0; stall_cnt=3.
REQ-028 mem_busy=1 for 4 cycles during load-use -> stall=1, state=MEMW, tracker frozen; after release load-use stall still taken once.
REQ-029 ex_branch_taken=1 with concurrent load-use -> flush_if_id=1, bubble_id_ex=1, stall=0, state=FLUSH next cycle; rs=x0 matches never hazard.
REQ-030 rst pulsed low during HAZ -> outputs 0, state=RUN, stall_cnt=0 asynchronously; 70000 stalled cycles -> stall_cnt=16'hFFFF.
